// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch slice.
//   fetch_entry_t : one prefetch entry, {pc, instr}
//   INSTR_BYTES   : bytes per instruction word (PC increment)
//   ADDR_W        : byte-address width
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int ADDR_W      = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t with flush.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, wr_entry      : write request and data
//   pop                 : consume head entry
//   flush               : discard all entries (wins over push and pop)
//   rd_entry            : head entry (undefined when empty)
//   full, empty, count  : occupancy status
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       wr_entry,
    output fetch_entry_t       rd_entry,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       cnt;
    logic                   do_push;
    logic                   do_pop;

    // A push into a full FIFO is only accepted when the head leaves this cycle.
    assign do_pop  = pop  && !flush && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Owns the fetch PC, reads a zero-latency instruction memory, queues
// {pc, instr} in a prefetch FIFO and hands entries to decode.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_addr / imem_data       : byte address out, combinational word in
//   redirect_valid, redirect_pc : one-cycle redirect from execute
//   inst_valid, inst_ready      : decode handshake
//   inst_data, inst_pc          : FIFO head (0 when empty)
//   fetch_fault                 : sticky misaligned-redirect / range fault
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                FIFO_DEPTH = 2,
    parameter int                MEM_WORDS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_fault
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * INSTR_BYTES);

    logic [ADDR_W-1:0] fetch_pc;
    logic              fault;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      head;
    fetch_entry_t      new_entry;
    logic              pop;
    logic              push;
    logic              can_fetch;
    logic              in_range;
    logic              range_fault;

    assign imem_addr = fetch_pc;
    assign in_range  = (fetch_pc < MEM_BYTES);

    // A redirect kills any head handshaking in the same cycle.
    assign pop         = inst_valid && inst_ready && !redirect_valid;
    assign can_fetch   = !redirect_valid && !fault && (!fifo_full || pop);
    assign push        = can_fetch && in_range;
    // The range check fires before fetch_pc can ever wrap past 2^32.
    assign range_fault = can_fetch && !in_range;

    assign new_entry.pc    = fetch_pc;
    assign new_entry.instr = imem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            fault    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            fault    <= |redirect_pc[1:0];
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);
        end else if (range_fault) begin
            fault    <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (new_entry),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign inst_valid  = (fifo_count != '0);
    assign inst_data   = fifo_empty ? 32'h0 : head.instr;
    assign inst_pc     = fifo_empty ? '0    : head.pc;
    assign fetch_fault = fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    logic [31:0] mem [32];
    fetch_entry_t exp_q [$];
    int checks;
    int errors;
    int accepted;
    int base;

    instr_fetch_unit #(
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2),
        .MEM_WORDS  (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    // Word k holds 0x11*(k+1): words 0..3 = 0x11,0x22,0x33,0x44.
    assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    initial begin
        fetch_entry_t e;
        checks   = 0;
        errors   = 0;
        accepted = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h11 * (i + 1);
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        fork
            // Monitor: every accepted head is popped against the scoreboard.
            begin
                forever begin
                    @(negedge clk);
                    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
                        checks++;
                        accepted++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_delivery actual pc=%h instr=%h expected none",
                                     inst_pc, inst_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (inst_pc !== e.pc || inst_data !== e.instr) begin
                                errors++;
                                $display("FAIL delivery actual pc=%h instr=%h expected pc=%h instr=%h",
                                         inst_pc, inst_data, e.pc, e.instr);
                            end
                        end
                    end
                end
            end
            begin
                tick();
                tick();
                // Reset state
                chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
                chk("rst_inst_data", inst_data, 32'h0);
                chk("rst_inst_pc", inst_pc, 32'h0);
                chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
                chk("rst_imem_addr", imem_addr, 32'h0);

                // Test 1: streaming with ready high
                expect_entry(32'h0, 32'h11);
                expect_entry(32'h4, 32'h22);
                expect_entry(32'h8, 32'h33);
                expect_entry(32'hC, 32'h44);
                inst_ready = 1'b1;
                base  = accepted;
                rst_n = 1'b1;
                tick();
                chk("t1_first_valid", {31'b0, inst_valid}, 32'h1);
                repeat (4) tick();
                inst_ready = 1'b0;
                chk("t1_throughput", 32'(accepted - base), 32'd4);
                tick();
                tick();
                chk("t6_full_head_valid", {31'b0, inst_valid}, 32'h1);
                chk("t6_full_head_pc", inst_pc, 32'h10);

                // Test 6: asynchronous reset with FIFO full
                rst_n = 1'b0;
                #1;
                chk("t6_valid_now", {31'b0, inst_valid}, 32'h0);
                chk("t6_data_now", inst_data, 32'h0);
                chk("t6_pc_now", inst_pc, 32'h0);
                chk("t6_addr_now", imem_addr, 32'h0);
                tick();

                // Test 2: stall fills the FIFO, then drain
                expect_entry(32'h0, 32'h11);
                expect_entry(32'h4, 32'h22);
                expect_entry(32'h8, 32'h33);
                rst_n = 1'b1;
                repeat (5) tick();
                chk("t2_stall_pc", inst_pc, 32'h0);
                chk("t2_stall_data", inst_data, 32'h11);
                chk("t2_stall_addr", imem_addr, 32'h8);
                inst_ready = 1'b1;
                base = accepted;
                repeat (3) tick();
                chk("t2_no_gaps", 32'(accepted - base), 32'd3);

                // Test 3: redirect while FIFO holds 0xC, 0x10 and head handshakes
                expect_entry(32'h40, 32'h121);
                redirect_valid = 1'b1;
                redirect_pc    = 32'h40;
                tick();
                redirect_valid = 1'b0;
                chk("t3_flush_valid", {31'b0, inst_valid}, 32'h0);
                chk("t3_addr", imem_addr, 32'h40);
                tick();
                chk("t3_target_valid", {31'b0, inst_valid}, 32'h1);
                chk("t3_target_pc", inst_pc, 32'h40);
                tick();
                inst_ready = 1'b0;

                // Test 4: misaligned redirect, then recovery
                redirect_valid = 1'b1;
                redirect_pc    = 32'h42;
                tick();
                redirect_valid = 1'b0;
                chk("t4_fault_set", {31'b0, fetch_fault}, 32'h1);
                repeat (3) tick();
                chk("t4_no_valid", {31'b0, inst_valid}, 32'h0);
                chk("t4_addr_held", imem_addr, 32'h42);
                expect_entry(32'h10, 32'h55);
                inst_ready     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = 32'h10;
                tick();
                redirect_valid = 1'b0;
                chk("t4_fault_clear", {31'b0, fetch_fault}, 32'h0);
                tick();
                chk("t4_recover_pc", inst_pc, 32'h10);
                tick();

                // Test 5: run off the end of memory
                expect_entry(32'h78, 32'h20F);
                expect_entry(32'h7C, 32'h220);
                base = accepted;
                redirect_valid = 1'b1;
                redirect_pc    = 32'h78;
                tick();
                redirect_valid = 1'b0;
                repeat (4) tick();
                chk("t5_delivered", 32'(accepted - base), 32'd2);
                chk("t5_fault", {31'b0, fetch_fault}, 32'h1);
                chk("t5_no_valid", {31'b0, inst_valid}, 32'h0);
                chk("t5_addr", imem_addr, 32'h80);

                // Reset clears the sticky fault and restarts at RESET_PC
                rst_n = 1'b0;
                #1;
                chk("t6_fault_cleared", {31'b0, fetch_fault}, 32'h0);
                tick();
                expect_entry(32'h0, 32'h11);
                rst_n = 1'b1;
                tick();
                chk("t6_restart_pc", inst_pc, 32'h0);
                tick();
                inst_ready = 1'b0;
                tick();
                chk("sb_drained", 32'(exp_q.size()), 32'h0);
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
